// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage parameters and entry types: reset PC, NOP encoding, buffer depth.
// No timing or backpressure of its own.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
    localparam int          BUF_DEPTH_DEF = 2;

    // One entry per granted request, matched to responses in order.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] pc;
    } tag_t;

    // One entry per instruction waiting for decode.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fbuf_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: imem request/response, redirect input, decode handoff.
// master = fetch stage, slave = environment (memory and decode).
interface fetch_stage_if;

    logic        o_IMemReq;
    logic [31:0] o_IMemAddr;
    logic        i_IMemGnt;
    logic        i_IMemRvalid;
    logic [31:0] i_IMemRdata;
    logic        i_Redirect;
    logic [31:0] i_RedirectPc;
    logic        i_Stall;
    logic        o_Valid;
    logic [31:0] o_Instr;
    logic [31:0] o_Pc;

    modport master (
        output o_IMemReq, o_IMemAddr, o_Valid, o_Instr, o_Pc,
        input  i_IMemGnt, i_IMemRvalid, i_IMemRdata, i_Redirect, i_RedirectPc, i_Stall
    );

    modport slave (
        input  o_IMemReq, o_IMemAddr, o_Valid, o_Instr, o_Pc,
        output i_IMemGnt, i_IMemRvalid, i_IMemRdata, i_Redirect, i_RedirectPc, i_Stall
    );

endinterface

// File: rtl/fetch_stage_fifo.sv
// Generic in-order queue with flush. Head is combinational, a push is visible next cycle.
// No internal backpressure: the caller keeps push within capacity; flush beats push/pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       core_clk,
    input  logic                       arst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    // Wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && !flush && (cnt != '0);
    assign do_push = push && !flush && ((cnt != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge core_clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge core_clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign count    = cnt;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: credit-limited imem requests, in-order tag queue, fetch buffer to decode.
// Response-to-o_Valid latency 1 cycle; i_Stall holds the buffer head and withholds credits.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    fetch_stage_if.master bus
);

    localparam int             CNT_W    = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W:0] CRED_MAX = (CNT_W + 1)'(BUF_DEPTH);

    logic [31:0]      pc_q;
    logic [CNT_W-1:0] discard_q;
    logic [CNT_W-1:0] discard_d;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] buffered;
    logic [CNT_W:0]   credit_used;
    logic [CNT_W:0]   in_flight;
    logic             buf_vld;
    logic             buf_pop;
    logic             req;
    logic             fire;
    logic             resp_take;
    logic             resp_drop;
    tag_t             tag_push;
    tag_t             tag_head;
    fbuf_t            buf_push;
    fbuf_t            buf_head;

    assign buf_vld = (buffered != '0);
    assign buf_pop = buf_vld && !bus.i_Stall && !bus.i_Redirect;

    // A slot freed by this cycle's pop can be re-requested at once, which keeps
    // a 1-cycle memory streaming every cycle; the sum never grows without a
    // grant, so an ungranted request stays asserted.
    assign credit_used = {1'b0, outstanding} + {1'b0, buffered} - {{CNT_W{1'b0}}, buf_pop};

    assign req  = !i_Rst && !bus.i_Redirect && (discard_q == '0) && (credit_used < CRED_MAX);
    assign fire = req && bus.i_IMemGnt;

    assign resp_take = bus.i_IMemRvalid && !bus.i_Redirect && (discard_q == '0) && (outstanding != '0);
    assign resp_drop = bus.i_IMemRvalid && (discard_q != '0);

    // On redirect everything still in the memory pipe becomes stale; a response
    // arriving in that same cycle is one of them and is consumed right away.
    assign in_flight = {1'b0, discard_q} + {1'b0, outstanding} + {{CNT_W{1'b0}}, fire};

    always_comb begin
        discard_d = discard_q;
        if (bus.i_Redirect) begin
            if (bus.i_IMemRvalid && (in_flight != '0)) discard_d = CNT_W'(in_flight - 1'b1);
            else                                      discard_d = CNT_W'(in_flight);
        end else if (resp_drop) begin
            discard_d = discard_q - 1'b1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            pc_q      <= RESET_PC;
            discard_q <= '0;
        end else begin
            discard_q <= discard_d;
            if (bus.i_Redirect) pc_q <= word_align(bus.i_RedirectPc);
            else if (fire)      pc_q <= pc_q + 32'd4;
        end
    end

    assign tag_push = '{addr: pc_q, pc: pc_q};

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(tag_t))
    ) u_tag_q (
        .core_clk (i_Clk),
        .arst     (i_Rst),
        .flush    (bus.i_Redirect),
        .push     (fire),
        .push_dat (tag_push),
        .pop      (resp_take),
        .head_dat (tag_head),
        .count    (outstanding)
    );

    assign buf_push = '{pc: tag_head.pc, instr: bus.i_IMemRdata};

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(fbuf_t))
    ) u_fetch_buf (
        .core_clk (i_Clk),
        .arst     (i_Rst),
        .flush    (bus.i_Redirect),
        .push     (resp_take),
        .push_dat (buf_push),
        .pop      (buf_pop),
        .head_dat (buf_head),
        .count    (buffered)
    );

    assign bus.o_IMemReq  = req;
    assign bus.o_IMemAddr = pc_q;
    assign bus.o_Valid    = buf_vld;
    assign bus.o_Instr    = buf_vld ? buf_head.instr : NOP_INSTR;
    assign bus.o_Pc       = buf_vld ? buf_head.pc    : RESET_PC;

    // Requests stop while stale responses drain, so the two counts never sum past the depth.
    assert property (@(posedge i_Clk) disable iff (i_Rst)
        (int'(discard_q) + int'(outstanding)) <= BUF_DEPTH);

    assert property (@(posedge i_Clk) disable iff (i_Rst)
        resp_take |-> (tag_head.addr == tag_head.pc) && (tag_head.addr[1:0] == 2'b00));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written redirect/reset sequences,
// then random grant/latency/stall/redirect against a program-order reference model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] RST_PC = RESET_PC_DEF;
    localparam int          DEPTH  = BUF_DEPTH_DEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] instr;
    } smp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } mreq_t;

    typedef struct {
        bit          pre_rst;
        bit          gnt;
        bit          stall;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_vld;
        logic [31:0] exp_pc;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          live = 0;
    int          buffered = 0;
    int          ndeliv = 0;
    logic [31:0] fetch_pc = RST_PC;
    logic [31:0] exp_pc = RST_PC;
    bit          ghost = 1'b0;
    mreq_t       memq[$];
    vec_t        vecs[15];
    smp_t        s;

    // Program image: every word address holds a distinct instruction.
    function automatic logic [31:0] prog(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.i_IMemGnt = 1'b0; bus.i_IMemRvalid = 1'b0; bus.i_IMemRdata = '0;
        bus.i_Redirect = 1'b0; bus.i_RedirectPc = '0; bus.i_Stall = 1'b0;
        #1;
        check("rst_req",   32'(bus.o_IMemReq), 32'd0);
        check("rst_vld",   32'(bus.o_Valid),   32'd0);
        check("rst_instr", bus.o_Instr,        NOP_INSTR);
        check("rst_pc",    bus.o_Pc,           RST_PC);
        memq.delete();
        epoch++;
        live = 0; buffered = 0;
        fetch_pc = RST_PC; exp_pc = RST_PC;
        @(posedge clk);
    endtask

    // One clock of stimulus plus reference-model checks; reset is released at the first call.
    task automatic cycle(input bit gnt, input bit stall, input bit redir,
                         input logic [31:0] rpc, input int lat, output smp_t o);
        bit    resp, resp_cur, pop_exp, req_exp;
        int    stale, due;
        mreq_t e;
        @(negedge clk);
        rst = 1'b0;
        bus.i_IMemGnt = gnt; bus.i_Stall = stall;
        bus.i_Redirect = redir; bus.i_RedirectPc = rpc;
        resp = 1'b0; resp_cur = 1'b0;
        if (ghost) begin
            bus.i_IMemRvalid = 1'b1; bus.i_IMemRdata = $urandom; ghost = 1'b0;
        end else begin
            resp = (memq.size() > 0) && (memq[0].due <= cyc);
            bus.i_IMemRvalid = resp;
            bus.i_IMemRdata  = resp ? prog(memq[0].addr) : $urandom;
            if (resp) resp_cur = (memq[0].ep == epoch);
        end
        #1;
        o.req = bus.o_IMemReq; o.addr = bus.o_IMemAddr; o.vld = bus.o_Valid;
        o.pc = bus.o_Pc; o.instr = bus.o_Instr;

        stale = 0;
        foreach (memq[i]) if (memq[i].ep != epoch) stale++;
        pop_exp = (buffered > 0) && !stall;
        req_exp = !redir && (stale == 0) && ((live - int'(pop_exp)) < DEPTH);
        check("m_req", 32'(o.req), 32'(req_exp));
        if (req_exp) check("m_addr", o.addr, fetch_pc);
        check("m_vld", 32'(o.vld), 32'(buffered > 0));
        if (buffered > 0) begin
            check("m_pc",    o.pc,    exp_pc);
            check("m_instr", o.instr, prog(exp_pc));
        end

        if (resp) e = memq.pop_front();
        if (redir) begin
            epoch++;
            live = 0; buffered = 0;
            fetch_pc = {rpc[31:2], 2'b00};
            exp_pc   = {rpc[31:2], 2'b00};
        end else begin
            if (pop_exp) begin
                buffered--; live--; exp_pc += 32'd4; ndeliv++;
            end
            if (o.req && gnt) begin
                due = cyc + lat;
                if (memq.size() > 0 && memq[$].due >= due) due = memq[$].due + 1;
                memq.push_back('{addr: o.addr, due: due, ep: epoch});
                live++;
                fetch_pc += 32'd4;
            end
            if (resp_cur) buffered++;
        end
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_IMemGnt = 1'b0; bus.i_IMemRvalid = 1'b0; bus.i_IMemRdata = '0;
        bus.i_Redirect = 1'b0; bus.i_RedirectPc = '0; bus.i_Stall = 1'b0;

        // pre_rst, gnt, stall, exp_req, exp_addr, exp_vld, exp_pc
        vecs[0]  = '{1, 1, 0, 1, 32'h00, 0, 32'h00};
        vecs[1]  = '{0, 1, 0, 1, 32'h04, 0, 32'h00};
        vecs[2]  = '{0, 1, 0, 1, 32'h08, 1, 32'h00};
        vecs[3]  = '{0, 1, 0, 1, 32'h0c, 1, 32'h04};
        vecs[4]  = '{0, 1, 0, 1, 32'h10, 1, 32'h08};
        vecs[5]  = '{0, 1, 0, 1, 32'h14, 1, 32'h0c};
        vecs[6]  = '{1, 1, 1, 1, 32'h00, 0, 32'h00};
        vecs[7]  = '{0, 1, 1, 1, 32'h04, 0, 32'h00};
        vecs[8]  = '{0, 1, 1, 0, 32'h00, 1, 32'h00};
        vecs[9]  = '{0, 1, 1, 0, 32'h00, 1, 32'h00};
        vecs[10] = '{0, 1, 1, 0, 32'h00, 1, 32'h00};
        vecs[11] = '{0, 1, 0, 1, 32'h08, 1, 32'h00};
        vecs[12] = '{0, 1, 0, 1, 32'h0c, 1, 32'h04};
        vecs[13] = '{0, 1, 0, 1, 32'h10, 1, 32'h08};
        vecs[14] = '{0, 1, 0, 1, 32'h14, 1, 32'h0c};

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].pre_rst) do_reset();
            cycle(vecs[i].gnt, vecs[i].stall, 1'b0, 32'h0, 1, s);
            check("v_req", 32'(s.req), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req) check("v_addr", s.addr, vecs[i].exp_addr);
            check("v_vld", 32'(s.vld), 32'(vecs[i].exp_vld));
            if (vecs[i].exp_vld) begin
                check("v_pc",    s.pc,    vecs[i].exp_pc);
                check("v_instr", s.instr, prog(vecs[i].exp_pc));
            end
        end

        // Two stale requests in a 3-cycle memory must drain before the redirect target is fetched.
        do_reset();
        cycle(1, 0, 0, 32'h0, 3, s);
        cycle(1, 0, 0, 32'h0, 3, s);
        cycle(1, 0, 1, 32'h103, 3, s);
        check("r36_req_redir", 32'(s.req), 32'd0);
        cycle(1, 0, 0, 32'h0, 3, s);
        check("r36_req_drop1", 32'(s.req), 32'd0);
        check("r36_vld_drop1", 32'(s.vld), 32'd0);
        cycle(1, 0, 0, 32'h0, 3, s);
        check("r36_req_drop2", 32'(s.req), 32'd0);
        check("r36_vld_drop2", 32'(s.vld), 32'd0);
        cycle(1, 0, 0, 32'h0, 3, s);
        check("r36_req_new",  32'(s.req), 32'd1);
        check("r36_addr_new", s.addr, 32'h100);
        for (int k = 0; k < 6; k++) cycle(1, 0, 0, 32'h0, 3, s);

        // Redirect alongside a grant and a would-be pop.
        do_reset();
        cycle(1, 1, 0, 32'h0, 1, s);
        cycle(1, 1, 0, 32'h0, 1, s);
        cycle(1, 1, 0, 32'h0, 1, s);
        check("r37_vld_pre", 32'(s.vld), 32'd1);
        cycle(1, 0, 1, 32'h200, 1, s);
        check("r37_req_redir", 32'(s.req), 32'd0);
        cycle(1, 0, 0, 32'h0, 1, s);
        check("r37_vld_post", 32'(s.vld), 32'd0);
        check("r37_req_post", 32'(s.req), 32'd1);
        check("r37_addr",     s.addr, 32'h200);
        cycle(1, 0, 0, 32'h0, 1, s);
        cycle(1, 0, 0, 32'h0, 1, s);
        check("r37_vld_tgt", 32'(s.vld), 32'd1);
        check("r37_pc_tgt",  s.pc, 32'h200);

        // Reset with responses pending; a stray response right after release is ignored.
        do_reset();
        cycle(1, 1, 0, 32'h0, 3, s);
        cycle(1, 1, 0, 32'h0, 3, s);
        cycle(1, 1, 0, 32'h0, 3, s);
        do_reset();
        ghost = 1'b1;
        cycle(1, 0, 0, 32'h0, 2, s);
        check("r38_req",  32'(s.req), 32'd1);
        check("r38_addr", s.addr, RST_PC);
        cycle(1, 0, 0, 32'h0, 2, s);
        check("r38_ghost_vld", 32'(s.vld), 32'd0);
        for (int k = 0; k < 6; k++) cycle(1, 0, 0, 32'h0, 2, s);

        // Random traffic against the reference model.
        do_reset();
        ndeliv = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            cycle(($urandom % 10) < 7, ($urandom % 10) < 3, ($urandom % 50) == 0,
                  $urandom & 32'h0000_0fff, $urandom_range(1, 4), s);
        end
        check("r39_progress", 32'(ndeliv > 400), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded at reset.
REQ-003 Parameter BUF_DEPTH, default 2, SHALL be the fetch buffer depth (credit limit).
REQ-004 Port i_Clk, input, 1 bit: clock.
REQ-005 Port i_Rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port o_IMemReq, output, 1 bit: instruction fetch request valid.
REQ-007 Port o_IMemAddr, output, 32 bits: fetch address, word aligned.
REQ-008 Port i_IMemGnt, input, 1 bit: request accepted this cycle.
REQ-009 Port i_IMemRvalid, input, 1 bit: response data valid.
REQ-010 Port i_IMemRdata, input, 32 bits: fetched instruction word.
REQ-011 Port i_Redirect, input, 1 bit: branch/jump taken, flush fetch.
REQ-012 Port i_RedirectPc, input, 32 bits: redirect target.
REQ-013 Port i_Stall, input, 1 bit: decode (immediate generator/ID) cannot accept.
REQ-014 Port o_Valid, output, 1 bit: o_Instr/o_Pc hold a valid instruction.
REQ-015 Port o_Instr, output, 32 bits: instruction to decode and imm_gen.
REQ-016 Port o_Pc, output, 32 bits: PC of o_Instr.

Function
REQ-017 PC register SHALL advance by 4 on each cycle with o_IMemReq && i_IMemGnt, and hold otherwise.
REQ-018 o_IMemReq SHALL be asserted when outstanding + buffered < BUF_DEPTH and i_Redirect is low; o_IMemAddr SHALL equal PC.
REQ-019 o_IMemReq and o_IMemAddr SHALL stay stable until granted.
REQ-020 Memory latency is one or more cycles; responses return in request order.
REQ-021 Each granted request SHALL push {addr, pc} into a BUF_DEPTH-entry in-order tag queue; each non-discarded response SHALL pair with the queue head and be written into the fetch buffer.
REQ-022 o_Valid SHALL equal buffer-not-empty; o_Instr/o_Pc SHALL show the buffer head combinationally.
REQ-023 The buffer SHALL pop when o_Valid && !i_Stall; push and pop in the same cycle SHALL both occur, count unchanged.
REQ-024 Credit rule guarantees the buffer never overflows; i_IMemRvalid with zero outstanding SHALL be ignored.
REQ-025 On i_Redirect: PC <= {i_RedirectPc[31:2], 2'b00}; buffer and tag queue cleared; outstanding count moved into discard counter; o_Valid low from the next cycle.
REQ-026 Responses arriving while the discard counter is nonzero SHALL be dropped and decrement it; no requests SHALL issue until discard reaches 0.
REQ-027 Redirect SHALL take priority over same-cycle grant, response and pop; a grant in the redirect cycle counts as outstanding-to-discard.
REQ-028 Back-to-back redirects SHALL accumulate discards; last target wins.
REQ-029 Outstanding and discard counters SHALL saturate-check to BUF_DEPTH (assertion, not logic).

Reset
REQ-030 On i_Rst: PC = RESET_PC, o_IMemReq = 0, o_Valid = 0, o_Instr = 32'h0000_0013 (NOP), o_Pc = RESET_PC, all counters and queues empty.
REQ-031 Reset mid-transaction SHALL abandon outstanding requests; a response in the first cycle after reset release SHALL be ignored.

Structure
REQ-032 RESET_PC default, NOP encoding 32'h0000_0013 and BUF_DEPTH default SHALL live in the shared parameters header.
REQ-033 The fetch buffer SHALL be a sub-module fetch_fifo (parameterised depth, 64-bit entry, push/pop/flush, count output).

Verification
REQ-034 Reset, i_IMemGnt=1, 1-cycle memory, i_Stall=0 -> addresses 0,4,8,... issued each cycle; o_Pc sequence 0,4,8 with matching o_Instr.
REQ-035 i_Stall held high 5 cycles -> after 2 grants o_IMemReq drops, o_Instr/o_Pc stable at PC 0; release -> stream resumes with no loss or duplication.
REQ-036 Two requests in flight, 3-cycle memory, i_Redirect with target 32'h0000_0103 -> next request address 32'h0000_0100 only after both stale responses are dropped; no stale instruction on o_Valid.
REQ-037 Redirect in the same cycle as grant and pop -> grant discarded, pop suppressed, PC = redirect target.
REQ-038 i_Rst asserted mid-fetch with responses pending -> outputs at reset values immediately; first fetch after release at RESET_PC.
REQ-039 Random grant/latency/stall with scoreboard -> delivered (pc, instr) pairs match the program in order, accounting for redirects.
